// File: rtl/arbitro_ula_pkg.sv
// Types shared by the arbiter and the ALU core.
package arbitro_ula_pkg;
`include "ula_defs.vh"

    typedef enum logic [1:0] {
        OCIOSO   = `EST_OCIOSO,
        CALCULA  = `EST_CALCULA,
        RESPONDE = `EST_RESPONDE
    } estado_t;

    typedef struct packed {
        logic [31:0] resultado;
        logic        zero;
        logic        erro;
    } ula_saida_t;
endpackage

// File: rtl/arbitro_ula_nucleo.sv
// Combinational 32-bit ALU: six ops, zero flag, unsupported-op flag.
`include "ula_defs.vh"

module ula_nucleo
    import arbitro_ula_pkg::*;
(
    input  logic [3:0]  operacao,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output ula_saida_t  saida
);

    always_comb begin
        saida = '0;
        case (operacao)
            `ULA_AND: saida.resultado = a & b;
            `ULA_OR:  saida.resultado = a | b;
            `ULA_ADD: saida.resultado = a + b;
            `ULA_SUB: saida.resultado = a - b;
            `ULA_SLT: saida.resultado = {31'b0, $signed(a) < $signed(b)};
            `ULA_NOR: saida.resultado = ~(a | b);
            default:  saida.erro      = 1'b1;
        endcase
        saida.zero = (saida.resultado == 32'd0);
    end

endmodule

// File: rtl/ula_defs.vh
// Shared op codes and FSM state codes for the ALU arbiter and its datapath.
`ifndef ULA_DEFS_VH
`define ULA_DEFS_VH

`define ULA_AND       4'b0000
`define ULA_OR        4'b0001
`define ULA_ADD       4'b0010
`define ULA_SUB       4'b0110
`define ULA_SLT       4'b0111
`define ULA_NOR       4'b1100

`define EST_OCIOSO    2'b00
`define EST_CALCULA   2'b01
`define EST_RESPONDE  2'b10

`endif

// File: rtl/arbitro_ula.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters; one op in flight.
module arbitro_ula
    import arbitro_ula_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valido,
    input  logic [4*NUM_REQ-1:0]  req_operacao,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_aceito,
    output logic                  resp_valido,
    input  logic                  resp_pronto,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_resultado,
    output logic                  resp_zero,
    output logic                  resp_erro
);

    estado_t         estado, prox;
    logic [ID_W-1:0] ponteiro, id_r, vencedor;
    logic            achou;
    logic [3:0]      op_r;
    logic [31:0]     a_r, b_r;
    ula_saida_t      ula;

    ula_nucleo u_nucleo (
        .operacao (op_r),
        .a        (a_r),
        .b        (b_r),
        .saida    (ula)
    );

    // Search starts just after the last served requester, wrapping around.
    always_comb begin
        achou    = 1'b0;
        vencedor = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!achou && req_valido[(int'(ponteiro) + k) % NUM_REQ]) begin
                achou    = 1'b1;
                vencedor = ID_W'((int'(ponteiro) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        prox       = estado;
        req_aceito = '0;
        case (estado)
            OCIOSO: begin
                if (achou) begin
                    req_aceito[vencedor] = 1'b1;
                    prox                 = CALCULA;
                end
            end
            CALCULA:  prox = RESPONDE;
            RESPONDE: if (resp_pronto) prox = OCIOSO;
            default:  prox = OCIOSO;
        endcase
    end

    assign resp_valido = (estado == RESPONDE);
    assign resp_id     = id_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado         <= OCIOSO;
            ponteiro       <= ID_W'(NUM_REQ - 1);
            id_r           <= '0;
            op_r           <= '0;
            a_r            <= '0;
            b_r            <= '0;
            resp_resultado <= '0;
            resp_zero      <= 1'b0;
            resp_erro      <= 1'b0;
        end else begin
            estado <= prox;
            if (estado == OCIOSO && achou) begin
                id_r <= vencedor;
                op_r <= req_operacao[4*int'(vencedor) +: 4];
                a_r  <= req_a[32*int'(vencedor) +: 32];
                b_r  <= req_b[32*int'(vencedor) +: 32];
            end
            if (estado == CALCULA) begin
                resp_resultado <= ula.resultado;
                resp_zero      <= ula.zero;
                resp_erro      <= ula.erro;
            end
            if (estado == RESPONDE && resp_pronto)
                ponteiro <= id_r;
        end
    end

endmodule

// File: tb/tb_arbitro_ula.sv
// Directed bench for arbitro_ula with hand-computed expected values.
module tb_arbitro_ula;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valido = '0;
    logic [4*NUM_REQ-1:0]  req_operacao = '0;
    logic [32*NUM_REQ-1:0] req_a = '0;
    logic [32*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]    req_aceito;
    logic                  resp_valido;
    logic                  resp_pronto = 1'b1;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_resultado;
    logic                  resp_zero;
    logic                  resp_erro;

    int n_vec = 0;
    int n_err = 0;

    arbitro_ula #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valido     (req_valido),
        .req_operacao   (req_operacao),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_aceito     (req_aceito),
        .resp_valido    (resp_valido),
        .resp_pronto    (resp_pronto),
        .resp_id        (resp_id),
        .resp_resultado (resp_resultado),
        .resp_zero      (resp_zero),
        .resp_erro      (resp_erro)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_operacao[4*i +: 4] = op;
        req_a[32*i +: 32]      = a;
        req_b[32*i +: 32]      = b;
        req_valido[i]          = 1'b1;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_aceito"}, 32'(req_aceito), 32'd0);
        chk({tag, "_valido"}, 32'(resp_valido), 32'd0);
        chk({tag, "_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_res"}, resp_resultado, 32'd0);
        chk({tag, "_zero"}, 32'(resp_zero), 32'd0);
        chk({tag, "_erro"}, 32'(resp_erro), 32'd0);
    endtask

    // Single isolated request from OCIOSO through the response handshake.
    task automatic run_op(input string tag, input int id, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ez, input logic ee);
        put(id, op, a, b);
        #1;
        chk({tag, "_aceito"}, 32'(req_aceito), 32'(1 << id));
        tick();
        req_valido = '0;
        chk({tag, "_calc"}, {31'b0, resp_valido} | 32'(req_aceito), 32'd0);
        tick();
        chk({tag, "_valido"}, 32'(resp_valido), 32'd1);
        chk({tag, "_id"}, 32'(resp_id), 32'(id));
        chk({tag, "_res"}, resp_resultado, er);
        chk({tag, "_zero"}, 32'(resp_zero), 32'(ez));
        chk({tag, "_erro"}, 32'(resp_erro), 32'(ee));
        tick();
    endtask

    initial begin
        #1;
        chk_zero_outs("rst");
        tick();
        reset = 1'b0;

        run_op("add5_7", 0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);

        // Fresh pointer, everyone requesting: rotation 0,1,2,3,0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) put(i, 4'b0110, 32'd9, 32'd9);
        #1;
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("rr%0d_aceito", g), 32'(req_aceito), 32'(1 << (g % NUM_REQ)));
            tick();
            chk($sformatf("rr%0d_calc", g), 32'(req_aceito), 32'd0);
            tick();
            chk($sformatf("rr%0d_resp_aceito", g), 32'(req_aceito), 32'd0);
            chk($sformatf("rr%0d_id", g), 32'(resp_id), 32'(g % NUM_REQ));
            chk($sformatf("rr%0d_res", g), {resp_resultado[30:0], resp_valido}, 32'd1);
            chk($sformatf("rr%0d_zero", g), 32'(resp_zero), 32'd1);
            if (g == 4) req_valido = '0;
            tick();
        end

        run_op("slt", 0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        run_op("addwrap", 0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        run_op("nor", 0, 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("badop", 0, 4'b0011, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
        run_op("or", 3, 4'b0001, 32'hA0, 32'h0B, 32'hAB, 1'b0, 1'b0);

        // Backpressure: response must hold, pending req1 must wait.
        resp_pronto = 1'b0;
        put(2, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
        #1;
        chk("bp_aceito2", 32'(req_aceito), 32'b0100);
        tick();
        req_valido = '0;
        put(1, 4'b0001, 32'd1, 32'd2);
        tick();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp%0d_hold", c), {resp_valido, 3'b0, req_aceito, 8'b0, resp_resultado[15:0]},
                {1'b1, 3'b0, 4'b0000, 8'b0, 16'hF000});
            chk($sformatf("bp%0d_id", c), 32'(resp_id), 32'd2);
            tick();
        end
        resp_pronto = 1'b1;
        tick();
        chk("bp_grant1", 32'(req_aceito), 32'b0010);
        tick();
        req_valido = '0;
        tick();
        chk("bp_res1", resp_resultado, 32'd3);
        chk("bp_id1", 32'(resp_id), 32'd1);
        tick();

        // Reset while the op is in CALCULA: discarded, outputs clear at once.
        put(2, 4'b0010, 32'd1, 32'd1);
        #1;
        chk("mid_aceito", 32'(req_aceito), 32'b0100);
        tick();
        req_valido = '0;
        reset = 1'b1;
        #1;
        chk_zero_outs("mid_rst");
        tick();
        tick();
        chk("mid_norsp", 32'(resp_valido), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_norsp2", 32'(resp_valido), 32'd0);
        put(3, 4'b0010, 32'd30, 32'd3);
        put(0, 4'b0010, 32'd10, 32'd0);
        #1;
        chk("post_first0", 32'(req_aceito), 32'b0001);
        tick();
        req_valido[0] = 1'b0;
        tick();
        chk("post_res0", resp_resultado, 32'd10);
        chk("post_id0", 32'(resp_id), 32'd0);
        tick();
        chk("post_then3", 32'(req_aceito), 32'b1000);
        tick();
        req_valido = '0;
        tick();
        chk("post_res3", resp_resultado, 32'd33);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
